// File: rtl/layer_compositor_if.sv
// layer_compositor_if: layer pixel bus in, composited pixel and sideband out
interface layer_compositor_if #(
  parameter int COLOR_BITS = 24,
  parameter int NUM_LAYERS = 4,
  parameter int CNT_BITS   = 20
);
  logic                             pixel_valid_i;
  logic                             display_enable_i;
  logic                             map_enable_i;
  logic                             hsync_i;
  logic                             vsync_i;
  logic [NUM_LAYERS-1:0]            layer_en_i;
  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_rgb_i;
  logic [1:0]                       mode_i;
  logic [COLOR_BITS-1:0]            key_color_i;
  logic [COLOR_BITS/3-1:0]          blue_o;
  logic [COLOR_BITS/3-1:0]          green_o;
  logic [COLOR_BITS/3-1:0]          red_o;
  logic                             pixel_valid_o;
  logic                             display_enable_o;
  logic                             hsync_o;
  logic                             vsync_o;
  logic                             collision_o;
  logic [CNT_BITS-1:0]              collision_frame_o;
  modport master (
    output pixel_valid_i, display_enable_i, map_enable_i, hsync_i, vsync_i,
           layer_en_i, layer_rgb_i, mode_i, key_color_i,
    input  blue_o, green_o, red_o, pixel_valid_o, display_enable_o,
           hsync_o, vsync_o, collision_o, collision_frame_o
  );
  modport slave (
    input  pixel_valid_i, display_enable_i, map_enable_i, hsync_i, vsync_i,
           layer_en_i, layer_rgb_i, mode_i, key_color_i,
    output blue_o, green_o, red_o, pixel_valid_o, display_enable_o,
           hsync_o, vsync_o, collision_o, collision_frame_o
  );
endinterface

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority/blend/OR compositor with aligned sideband and per-frame collision count
module layer_compositor #(
  parameter int                    COLOR_BITS   = 24,
  parameter int                    NUM_LAYERS   = 4,
  parameter logic [COLOR_BITS-1:0] BORDER_COLOR = COLOR_BITS'(24'hE0E0E0),
  parameter int                    CNT_BITS     = 20
) (
  input logic               clk_i,
  input logic               rst_i,
  layer_compositor_if.slave bus
);
  localparam int CW = COLOR_BITS / 3;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  logic                  r_vs_prev;
  logic [1:0]            r_mode;
  logic [COLOR_BITS-1:0] r_key;
  logic                  w_vs_rise;
  logic [1:0]            w_mode;
  logic [COLOR_BITS-1:0] w_key;
  logic                  w_or_mode;
  logic [NUM_LAYERS-1:0] w_opq;
  logic [COLOR_BITS-1:0] w_px;
  logic [COLOR_BITS-1:0] w_top;
  logic [COLOR_BITS-1:0] w_sec;
  logic                  w_sec_v;
  logic                  w_top_v;
  logic [COLOR_BITS-1:0] w_or;
  logic [3:0]            w_ncol;
  logic                  w_coll;
  logic [COLOR_BITS-1:0] r_top;
  logic [COLOR_BITS-1:0] r_sec;
  logic                  r_sec_v;
  logic [COLOR_BITS-1:0] r_or;
  logic                  r_or_mode;
  logic                  r_blend;
  logic [4:0]            r_sb1;
  logic                  r_col1;
  logic [COLOR_BITS-1:0] w_blend;
  logic [COLOR_BITS-1:0] w_rgb;
  logic [COLOR_BITS-1:0] r_rgb;
  logic [3:0]            r_sb2;
  logic                  r_col;
  logic [CNT_BITS-1:0]   r_cnt;
  logic [CNT_BITS-1:0]   r_frame;
  // Config seen by this pixel (a vsync rise applies the new values immediately) and opaque-layer ranking
  always_comb begin
    w_vs_rise = bus.vsync_i & ~r_vs_prev;
    w_mode    = w_vs_rise ? bus.mode_i : r_mode;
    w_key     = w_vs_rise ? bus.key_color_i : r_key;
    w_or_mode = (w_mode == 2'b00) | (w_mode == 2'b11);
    w_opq     = '0;
    w_px      = '0;
    w_top     = '0;
    w_top_v   = 1'b0;
    w_sec     = '0;
    w_sec_v   = 1'b0;
    w_or      = '0;
    w_ncol    = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_px     = bus.layer_rgb_i[k*COLOR_BITS +: COLOR_BITS];
      w_opq[k] = bus.layer_en_i[k] & (w_or_mode | (w_px != w_key));
      w_or     = bus.layer_en_i[k] ? (w_or | w_px) : w_or;
      if (w_opq[k]) begin
        w_sec   = w_top;
        w_sec_v = w_top_v;
        w_top   = w_px;
        w_top_v = 1'b1;
        w_ncol  = (k > 0) ? w_ncol + 4'd1 : w_ncol;
      end
    end
    w_coll = bus.display_enable_i & bus.map_enable_i & bus.pixel_valid_i & (w_ncol >= 4'd2);
  end
  // Shadow mode/key on the vsync rising edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vs_prev <= 1'b0;
      r_mode    <= 2'b00;
      r_key     <= '0;
    end else begin
      r_vs_prev <= bus.vsync_i;
      r_mode    <= w_mode;
      r_key     <= w_key;
    end
  end
  // Stage 1: top two opaque pixels, OR of enabled layers, mode flags and sideband
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_top     <= '0;
      r_sec     <= '0;
      r_sec_v   <= 1'b0;
      r_or      <= '0;
      r_or_mode <= 1'b0;
      r_blend   <= 1'b0;
      r_sb1     <= '0;
      r_col1    <= 1'b0;
    end else begin
      r_top     <= w_top;
      r_sec     <= w_sec;
      r_sec_v   <= w_sec_v;
      r_or      <= w_or;
      r_or_mode <= w_or_mode;
      r_blend   <= (w_mode == 2'b10);
      r_sb1     <= {bus.pixel_valid_i, bus.display_enable_i, bus.map_enable_i, bus.hsync_i, bus.vsync_i};
      r_col1    <= w_coll;
    end
  end
  // Stage 2 colour select; halving each channel before adding cannot overflow
  always_comb begin
    w_blend = '0;
    for (int c = 0; c < 3; c++)
      w_blend[c*CW +: CW] = (r_top[c*CW +: CW] >> 1) + (r_sec[c*CW +: CW] >> 1);
    w_rgb = !r_sb1[3] ? '0 : !r_sb1[2] ? BORDER_COLOR : r_or_mode ? r_or : (r_blend & r_sec_v) ? w_blend : r_top;
  end
  // Stage 2 output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rgb <= '0;
      r_sb2 <= '0;
      r_col <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_sb2 <= {r_sb1[4], r_sb1[3], r_sb1[1], r_sb1[0]};
      r_col <= r_col1;
    end
  end
  // Saturating collision counter; a colliding pixel on the vsync edge opens the next frame's count
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_frame <= '0;
    end else if (w_vs_rise) begin
      r_frame <= r_cnt;
      r_cnt   <= w_coll ? CNT_BITS'(1) : '0;
    end else if (w_coll && r_cnt != CNT_MAX) begin
      r_cnt   <= r_cnt + CNT_BITS'(1);
    end
  end
  assign bus.blue_o            = r_rgb[2*CW +: CW];
  assign bus.green_o           = r_rgb[CW +: CW];
  assign bus.red_o             = r_rgb[0 +: CW];
  assign bus.pixel_valid_o     = r_sb2[3];
  assign bus.display_enable_o  = r_sb2[2];
  assign bus.hsync_o           = r_sb2[1];
  assign bus.vsync_o           = r_sb2[0];
  assign bus.collision_o       = r_col;
  assign bus.collision_frame_o = r_frame;
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: random and directed stimulus against a behavioural compositor model
module tb_layer_compositor;
  typedef struct packed {
    logic [23:0] rgb;
    logic        pv;
    logic        de;
    logic        hs;
    logic        vs;
    logic        col;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  layer_compositor_if #(.COLOR_BITS(24), .NUM_LAYERS(4), .CNT_BITS(20)) if_a ();
  layer_compositor_if #(.COLOR_BITS(24), .NUM_LAYERS(4), .CNT_BITS(4))  if_b ();
  layer_compositor #(.COLOR_BITS(24), .NUM_LAYERS(4), .CNT_BITS(20)) dut_a (.clk_i(clk), .rst_i(rst), .bus(if_a));
  layer_compositor #(.COLOR_BITS(24), .NUM_LAYERS(4), .CNT_BITS(4))  dut_b (.clk_i(clk), .rst_i(rst), .bus(if_b));
  assign if_b.pixel_valid_i    = if_a.pixel_valid_i;
  assign if_b.display_enable_i = if_a.display_enable_i;
  assign if_b.map_enable_i     = if_a.map_enable_i;
  assign if_b.hsync_i          = if_a.hsync_i;
  assign if_b.vsync_i          = if_a.vsync_i;
  assign if_b.layer_en_i       = if_a.layer_en_i;
  assign if_b.layer_rgb_i      = if_a.layer_rgb_i;
  assign if_b.mode_i           = if_a.mode_i;
  assign if_b.key_color_i      = if_a.key_color_i;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int col_seen = 0;
  int m_mode;
  logic [23:0] m_key;
  logic m_prev;
  int cnt_a, cnt_b;
  logic [19:0] fr_a;
  logic [3:0] fr_b;
  exp_t pend, outx;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Composite one pixel from the rules: rank opaque layers from the top down, then pick by mode
  function automatic exp_t model_px(input int mode, input logic [23:0] key, input logic [3:0] en,
                                    input logic [95:0] rgb, input logic pv, de, me, hs, vs);
    exp_t e;
    int top = -1, sec = -1, n = 0;
    logic [23:0] orv = 0, pt, ps, bl;
    for (int k = 3; k >= 0; k--) begin
      if (en[k]) orv |= rgb[k*24 +: 24];
      if (en[k] && (mode == 0 || rgb[k*24 +: 24] != key)) begin
        if (top < 0) top = k;
        else if (sec < 0) sec = k;
        if (k > 0) n++;
      end
    end
    pt = (top >= 0) ? rgb[top*24 +: 24] : 24'h0;
    ps = (sec >= 0) ? rgb[sec*24 +: 24] : 24'h0;
    for (int c = 0; c < 3; c++) bl[c*8 +: 8] = 8'(pt[c*8 +: 8] / 2 + ps[c*8 +: 8] / 2);
    e.rgb = !de ? 24'h0 : !me ? 24'hE0E0E0 : mode == 0 ? orv : top < 0 ? 24'h0 :
            (mode == 2 && sec >= 0) ? bl : pt;
    e.pv = pv;
    e.de = de;
    e.hs = hs;
    e.vs = vs;
    e.col = de & me & pv & (n >= 2);
    return e;
  endfunction
  // Reference model: advances on each clock, clears on reset
  initial forever begin
    exp_t e;
    logic rise;
    @(posedge clk or posedge rst);
    if (rst) begin
      m_mode = 0; m_key = 0; m_prev = 0; cnt_a = 0; cnt_b = 0; fr_a = 0; fr_b = 0;
      pend = '0; outx = '0;
    end else begin
      rise = if_a.vsync_i && !m_prev;
      m_prev = if_a.vsync_i;
      if (rise) begin
        m_mode = (if_a.mode_i == 2'd3) ? 0 : int'(if_a.mode_i);
        m_key = if_a.key_color_i;
      end
      e = model_px(m_mode, m_key, if_a.layer_en_i, if_a.layer_rgb_i, if_a.pixel_valid_i,
                   if_a.display_enable_i, if_a.map_enable_i, if_a.hsync_i, if_a.vsync_i);
      outx = pend;
      pend = e;
      if (rise) begin
        fr_a = 20'(cnt_a); fr_b = 4'(cnt_b);
        cnt_a = int'(e.col); cnt_b = int'(e.col);
      end else begin
        cnt_a = (cnt_a + int'(e.col) > 20'hFFFFF) ? 20'hFFFFF : cnt_a + int'(e.col);
        cnt_b = (cnt_b + int'(e.col) > 15) ? 15 : cnt_b + int'(e.col);
      end
    end
  end
  // Compare both DUTs against the model every cycle, away from the clock edge
  always @(negedge clk) begin
    if (if_a.collision_o === 1'b1) col_seen++;
    if (chk_on) begin
      chk("rgb_a", {if_a.blue_o, if_a.green_o, if_a.red_o}, outx.rgb);
      chk("rgb_b", {if_b.blue_o, if_b.green_o, if_b.red_o}, outx.rgb);
      chk("pv_o", if_a.pixel_valid_o, outx.pv);
      chk("de_o", if_a.display_enable_o, outx.de);
      chk("hs_o", if_a.hsync_o, outx.hs);
      chk("vs_o", if_a.vsync_o, outx.vs);
      chk("col_a", if_a.collision_o, outx.col);
      chk("col_b", if_b.collision_o, outx.col);
      chk("frame_a", if_a.collision_frame_o, fr_a);
      chk("frame_b", if_b.collision_frame_o, fr_b);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic setpx(input logic [3:0] en, input logic [23:0] l3, l2, l1, l0);
    if_a.layer_en_i = en;
    if_a.layer_rgb_i = {l3, l2, l1, l0};
  endtask
  task automatic hold_chk(input string nm, input logic [23:0] exp);
    step();
    step();
    chk(nm, {if_a.blue_o, if_a.green_o, if_a.red_o}, exp);
    chk({nm, "_model"}, outx.rgb, exp);
  endtask
  task automatic vs_edge();
    if_a.vsync_i = 1'b1;
    step();
    if_a.vsync_i = 1'b0;
  endtask
  initial begin
    int base;
    if_a.pixel_valid_i = 1'b1;
    if_a.display_enable_i = 1'b0;
    if_a.map_enable_i = 1'b1;
    if_a.hsync_i = 1'b0;
    if_a.vsync_i = 1'b0;
    if_a.mode_i = 2'b00;
    if_a.key_color_i = 24'h0;
    setpx(4'b1111, 24'h111111, 24'h222222, 24'h333333, 24'h444444);
    step();
    chk_on = 1'b1;
    repeat (3) step();
    chk("reset_rgb", {if_a.blue_o, if_a.green_o, if_a.red_o}, 24'h0);
    chk("reset_frame", if_a.collision_frame_o, 20'h0);
    @(negedge clk) rst = 1'b0;
    repeat (10) step();
    chk("de0_rgb", {if_a.blue_o, if_a.green_o, if_a.red_o}, 24'h0);
    chk("de0_col", if_a.collision_o, 1'b0);
    if_a.display_enable_i = 1'b1;
    setpx(4'b0111, 24'h0, 24'h330000, 24'h002200, 24'h000011);
    hold_chk("or_mix", 24'h332211);
    if_a.map_enable_i = 1'b0;
    hold_chk("border", 24'hE0E0E0);
    if_a.map_enable_i = 1'b1;
    if_a.hsync_i = 1'b1;
    step();
    chk("hs_d1", if_a.hsync_o, 1'b0);
    if_a.hsync_i = 1'b0;
    step();
    chk("hs_d2", if_a.hsync_o, 1'b1);
    step();
    chk("hs_d3", if_a.hsync_o, 1'b0);
    if_a.mode_i = 2'b01;
    if_a.key_color_i = 24'h0;
    setpx(4'b1111, 24'h0, 24'h123456, 24'h002200, 24'h000011);
    hold_chk("midframe_mode", 24'h123657);
    if_a.vsync_i = 1'b1;
    setpx(4'b1100, 24'h0, 24'h123456, 24'h0, 24'h0);
    hold_chk("key_top", 24'h123456);
    if_a.vsync_i = 1'b0;
    setpx(4'b1111, 24'h0, 24'h0, 24'h0, 24'h0);
    hold_chk("all_key", 24'h0);
    if_a.mode_i = 2'b10;
    if_a.vsync_i = 1'b1;
    setpx(4'b1010, 24'hFFFFFF, 24'h0, 24'h020202, 24'h0);
    hold_chk("blend", 24'h808080);
    if_a.vsync_i = 1'b0;
    setpx(4'b0001, 24'h0, 24'h0, 24'h0, 24'h0A0B0C);
    hold_chk("blend_single", 24'h0A0B0C);
    vs_edge();
    base = col_seen;
    for (int i = 0; i < 5; i++) begin
      setpx(4'b0110, 24'h0, 24'h020202, 24'h010101, 24'h0);
      if_a.pixel_valid_i = (i != 2);
      step();
    end
    if_a.pixel_valid_i = 1'b1;
    setpx(4'b0001, 24'h0, 24'h0, 24'h0, 24'h0A0B0C);
    repeat (3) step();
    chk("col_pulses", col_seen - base, 4);
    setpx(4'b0110, 24'h0, 24'h020202, 24'h010101, 24'h0);
    vs_edge();
    chk("frame_cnt_a", if_a.collision_frame_o, 20'd4);
    chk("frame_cnt_b", if_b.collision_frame_o, 4'd4);
    setpx(4'b0001, 24'h0, 24'h0, 24'h0, 24'h0A0B0C);
    step();
    vs_edge();
    chk("edge_carry", if_a.collision_frame_o, 20'd1);
    for (int i = 0; i < 20; i++) begin
      setpx(4'b0110, 24'h0, 24'h020202, 24'h010101, 24'h0);
      step();
    end
    setpx(4'b0001, 24'h0, 24'h0, 24'h0, 24'h0A0B0C);
    vs_edge();
    chk("cnt20_a", if_a.collision_frame_o, 20'd20);
    chk("sat_b", if_b.collision_frame_o, 4'd15);
    setpx(4'b0110, 24'h0, 24'h020202, 24'h010101, 24'h0);
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("rst_rgb", {if_a.blue_o, if_a.green_o, if_a.red_o}, 24'h0);
    chk("rst_col", if_a.collision_o, 1'b0);
    chk("rst_frame", if_a.collision_frame_o, 20'h0);
    setpx(4'b0001, 24'h0, 24'h0, 24'h0, 24'h0A0B0C);
    @(negedge clk) rst = 1'b0;
    step();
    setpx(4'b0110, 24'h0, 24'h020202, 24'h010101, 24'h0);
    repeat (2) step();
    setpx(4'b0001, 24'h0, 24'h0, 24'h0, 24'h0A0B0C);
    vs_edge();
    chk("partial_frame", if_a.collision_frame_o, 20'd2);
    for (int i = 0; i < 3000; i++) begin
      logic [23:0] px;
      if_a.pixel_valid_i = ($urandom % 8) != 0;
      if_a.display_enable_i = ($urandom % 8) != 0;
      if_a.map_enable_i = ($urandom % 6) != 0;
      if_a.hsync_i = 1'($urandom % 2);
      if ($urandom % 40 == 0) if_a.vsync_i = ~if_a.vsync_i;
      if_a.mode_i = 2'($urandom % 4);
      if ($urandom % 50 == 0) if_a.key_color_i = ($urandom % 2) ? 24'h00FF00 : 24'($urandom);
      if_a.layer_en_i = 4'($urandom);
      for (int k = 0; k < 4; k++) begin
        case ($urandom % 4)
          0: px = 24'h00FF00;
          1: px = if_a.key_color_i;
          default: px = 24'($urandom);
        endcase
        if_a.layer_rgb_i[k*24 +: 24] = px;
      end
      step();
    end
    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
